uart_frame_sched: RTL and testbench
===================================

Name: uart_frame_sched

Overview:
Frame scheduler that owns the byte-wide UART transmitter. It accepts 32-bit frequency measurement words from the measurement path and sequences each word into a framed byte stream, one byte at a time, using the transmitter's tx_en/tx_done handshake. A one-deep pending buffer absorbs a measurement that arrives while a frame is in flight. An inter-frame gap keeps the receiving host in sync.

Parameters:
GAP_CYCLES, 16, idle sys_clk cycles between the last byte's tx_done and the next frame's first tx_en; 0 is legal.
HDR_BYTE, 8'hAA, first byte of every frame.
TAIL_BYTE, 8'h55, last byte of every frame.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
meas_data  in  32  measurement word; valid only while meas_valid=1
meas_valid  in  1  single-cycle strobe presenting meas_data
tx_data  out  8  byte to the transmitter; stable from tx_en until tx_done
tx_en  out  1  one-cycle start pulse to the transmitter
tx_done  in  1  one-cycle pulse from the transmitter: byte fully sent, stop bit included
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse on the cycle after the tail byte's tx_done
drop_cnt  out  8  count of dropped measurements; saturates at 255

Behaviour:
- Reset: all outputs 0 (tx_data=0, tx_en=0, busy=0, frame_done=0, drop_cnt=0). Pending slot empty, state IDLE.
- Reset asserted mid-frame aborts the frame at once. No further tx_en is issued.
- Frame format: HDR, D[31:24], D[23:16], D[15:8], D[7:0], CHK, TAIL (7 bytes).
- CHK = (D[31:24]+D[23:16]+D[15:8]+D[7:0]) mod 256, computed in 10-bit arithmetic and truncated to 8 bits.
- State machine and transitions:
  - IDLE: on meas_valid, latch meas_data into the frame register and go to SEND.
  - SEND: drive tx_data and pulse tx_en for exactly 1 cycle; go to WAIT.
  - WAIT: hold tx_data. On tx_done, advance the byte index. If bytes remain, go to SEND on the next cycle, so tx_en comes 1 cycle after tx_done. After the tail byte, pulse frame_done and go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE, or go straight to SEND if the pending slot is full. The pending word is moved into the frame register on that transition, which empties the slot.
- Latency: meas_valid sampled in cycle N in IDLE gives tx_en in cycle N+1 with tx_data=HDR_BYTE.
- Pending slot: meas_valid while not IDLE writes the slot if it is empty. If the slot is full, the new word is dropped and drop_cnt increments.
- Simultaneous events:
  - meas_valid in the same cycle the slot is consumed: the new word is stored, not dropped.
  - meas_valid in IDLE goes straight to the frame register; the slot stays empty.
- tx_done received outside WAIT is ignored.
- tx_en is never asserted while a byte is outstanding. The block relies on the transmitter latching data on tx_en.
- GAP_CYCLES=0: the GAP state is bypassed, so the next frame's tx_en comes 1 cycle after frame_done.

Optional Feature:
Macro FRAME_CHK_EN.
- Defined: the CHK byte is sent; frames are 7 bytes, as above.
- Undefined: no CHK byte and no checksum logic; frames are 6 bytes (HDR, D3..D0, TAIL). All other timing is unchanged.

Test Plan:
- Single word (FRAME_CHK_EN defined): meas_data=32'h12345678 pulsed in IDLE -> tx_data sequence AA 12 34 56 78 14 55. Exactly 7 tx_en pulses, each 1 cycle after the previous tx_done. frame_done once. busy low after GAP_CYCLES.
- Checksum wrap: meas_data=32'hFFFFFFFF -> bytes AA FF FF FF FF FC 55. With FRAME_CHK_EN undefined, the same word gives AA FF FF FF FF 55.
- Back-to-back with drop: pulse 32'h00000001 in IDLE, then 32'h00000002 and 32'h00000003 mid-frame. Result: frame for 1; frame for 2 starting exactly GAP_CYCLES after frame_done; 3 dropped, drop_cnt=1.
- Simultaneous consume: meas_valid carrying 32'hA5A5A5A5 in the same cycle GAP moves the pending word to the frame register -> A5A5A5A5 is sent as the following frame and drop_cnt is unchanged.
- Reset mid-frame: deassert sys_rst_n during byte 3's WAIT -> all outputs 0 immediately. After release, no tx_en until a new meas_valid, and the next frame starts with AA.
- Saturation: 300 drops forced by holding the scheduler busy with a stalled tx_done -> drop_cnt holds at 255.

Source files
------------

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: sequences 32-bit measurement words into framed byte
// streams for a byte-wide UART transmitter (tx_en / tx_done handshake).
// Frame: HDR, D[31:24], D[23:16], D[15:8], D[7:0], [CHK], TAIL.
// Build option: define FRAME_CHK_EN to insert the additive checksum byte
// (7-byte frames); with it undefined, frames are 6 bytes with no checksum logic.
//
// Handshake: tx_en is a one-cycle start pulse issued with tx_data already
// valid; tx_data then holds until the transmitter answers with a one-cycle
// tx_done. Only one byte is ever outstanding. tx_done outside WAIT is ignored.
module uart_frame_sched #(
   parameter int unsigned GAP_CYCLES = 16,
   parameter logic [7:0]  HDR_BYTE   = 8'hAA,
   parameter logic [7:0]  TAIL_BYTE  = 8'h55
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [31:0] meas_data,
   input  logic        meas_valid,
   output logic [7:0]  tx_data,
   output logic        tx_en,
   input  logic        tx_done,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  drop_cnt,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

`ifdef FRAME_CHK_EN
   localparam logic [2:0] LAST_IDX = 3'd6;
`else
   localparam logic [2:0] LAST_IDX = 3'd5;
`endif

   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   state_t        state;
   logic [2:0]    byte_idx;
   logic [31:0]   frame_reg;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   pend_word;
   logic          pend_full;
   logic [7:0]    next_byte;
   logic          start_pend;

`ifdef FRAME_CHK_EN
   logic [9:0] chk_sum;

   // Checksum of the word in flight, summed wide and truncated on use.
   always_comb begin
      chk_sum = 10'(frame_reg[31:24]) + 10'(frame_reg[23:16])
              + 10'(frame_reg[15:8])  + 10'(frame_reg[7:0]);
   end
`endif

   // Byte that follows the current one; the header is loaded directly at frame start.
   always_comb begin
      next_byte = TAIL_BYTE;
      case (byte_idx + 3'd1)
         3'd1:    next_byte = frame_reg[31:24];
         3'd2:    next_byte = frame_reg[23:16];
         3'd3:    next_byte = frame_reg[15:8];
         3'd4:    next_byte = frame_reg[7:0];
`ifdef FRAME_CHK_EN
         3'd5:    next_byte = chk_sum[7:0];
`endif
         default: next_byte = TAIL_BYTE;
      endcase
   end

   // The pending word launches a frame from IDLE, or at the final GAP cycle.
   assign start_pend = pend_full &&
                       ((state == ST_IDLE) ||
                        ((state == ST_GAP) && (gap_cnt == GAP_LAST)));

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Frame sequencer: header/data/tail byte issue, handshake wait and inter-frame gap.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         byte_idx   <= 3'd0;
         frame_reg  <= 32'd0;
         gap_cnt    <= '0;
         tx_data    <= 8'd0;
         tx_en      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         tx_en      <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pend_full || meas_valid) begin
                  frame_reg <= pend_full ? pend_word : meas_data;
                  byte_idx  <= 3'd0;
                  tx_data   <= HDR_BYTE;
                  tx_en     <= 1'b1;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_done) begin
                  if (byte_idx == LAST_IDX) begin
                     frame_done <= 1'b1;
                     gap_cnt    <= '0;
                     // With no gap, IDLE picks up any pending word one cycle later.
                     state      <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     tx_data  <= next_byte;
                     tx_en    <= 1'b1;
                     state    <= ST_SEND;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (pend_full) begin
                     frame_reg <= pend_word;
                     byte_idx  <= 3'd0;
                     tx_data   <= HDR_BYTE;
                     tx_en     <= 1'b1;
                     state     <= ST_SEND;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // One-deep pending slot and saturating drop counter.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pend_word <= 32'd0;
         pend_full <= 1'b0;
         drop_cnt  <= 8'd0;
      end else begin
         if (start_pend) begin
            // Slot empties this cycle, so a concurrent word takes its place.
            pend_full <= meas_valid;
            if (meas_valid) begin
               pend_word <= meas_data;
            end
         end else if (meas_valid && (state != ST_IDLE)) begin
            if (!pend_full) begin
               pend_full <= 1'b1;
               pend_word <= meas_data;
            end else if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_sched.sv
// tb_uart_frame_sched: directed bench for uart_frame_sched with the default
// 16-cycle inter-frame gap. Frame length follows FRAME_CHK_EN.
module tb_uart_frame_sched;

  localparam int G = 16;
`ifdef FRAME_CHK_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] meas_data;
  logic        meas_valid;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_done;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  uart_frame_sched #(
    .GAP_CYCLES (G),
    .HDR_BYTE   (8'hAA),
    .TAIL_BYTE  (8'h55)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .meas_data  (meas_data),
    .meas_valid (meas_valid),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // expected byte i of a frame carrying d with hand-computed checksum c
  function automatic logic [7:0] eb(input logic [31:0] d, input logic [7:0] c, input int i);
    logic [7:0] b;
    case (i)
      0: b = 8'hAA;
      1: b = d[31:24];
      2: b = d[23:16];
      3: b = d[15:8];
      4: b = d[7:0];
      5: b = (NB == 7) ? c : 8'h55;
      default: b = 8'h55;
    endcase
    return b;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // driver: one-cycle meas_valid strobe; returns on the negedge where the header tx_en shows
  task automatic send_meas(input logic [31:0] d);
    meas_data  = d;
    meas_valid = 1'b1;
    @(negedge sys_clk);
    meas_valid = 1'b0;
  endtask

  // plays the transmitter for one frame; entered on the negedge showing the header tx_en
  task automatic run_frame(input logic [31:0] d, input logic [7:0] c, input int dly,
                           input int ia, input logic [31:0] da,
                           input int ib, input logic [31:0] db);
    for (int i = 0; i < NB; i++) begin
      chk("tx_en_pulse", tx_en, 1);
      chk("tx_data_byte", tx_data, eb(d, c, i));
      for (int j = 0; j < dly; j++) begin
        if (j == 0 && i == ia) begin
          meas_data = da; meas_valid = 1'b1;
        end else if (j == 0 && i == ib) begin
          meas_data = db; meas_valid = 1'b1;
        end
        @(negedge sys_clk);
        meas_valid = 1'b0;
      end
      chk("tx_en_low_in_wait", tx_en, 0);
      chk("tx_data_hold", tx_data, eb(d, c, i));
      chk("frame_done_early", frame_done, 0);
      tx_done = 1'b1;
      @(negedge sys_clk);
      tx_done = 1'b0;
    end
    chk("frame_done_pulse", frame_done, 1);
    chk("tx_en_after_tail", tx_en, 0);
    chk("busy_in_gap", busy, 1);
  endtask

  // walks the gap after frame_done; optionally strobes a word on the final gap cycle
  task automatic run_gap(input bit expect_next, input bit inj, input logic [31:0] di);
    for (int k = 1; k < G; k++) begin
      @(negedge sys_clk);
      chk("gap_busy", busy, 1);
      chk("gap_tx_en", tx_en, 0);
      if (k == 1) chk("frame_done_single", frame_done, 0);
      if (inj && k == G - 1) begin
        meas_data = di; meas_valid = 1'b1;
      end
    end
    @(negedge sys_clk);
    meas_valid = 1'b0;
    if (expect_next) begin
      chk("next_frame_tx_en", tx_en, 1);
    end else begin
      chk("idle_after_gap_busy", busy, 0);
      chk("idle_after_gap_tx_en", tx_en, 0);
    end
  endtask

  initial begin
    int en_seen;
    sys_rst_n  = 1'b0;
    meas_data  = 32'd0;
    meas_valid = 1'b0;
    tx_done    = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_zero("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("idle_tx_en", tx_en, 0);

    // single word
    send_meas(32'h12345678);
    run_frame(32'h12345678, 8'h14, 3, -1, 0, -1, 0);
    run_gap(0, 0, 0);

    // checksum wrap
    send_meas(32'hFFFFFFFF);
    run_frame(32'hFFFFFFFF, 8'hFC, 1, -1, 0, -1, 0);
    run_gap(0, 0, 0);

    // back-to-back with one drop
    send_meas(32'h00000001);
    run_frame(32'h00000001, 8'h01, 2, 1, 32'h00000002, 3, 32'h00000003);
    chk("drop_after_b2b", drop_cnt, 1);
    run_gap(1, 0, 0);
    run_frame(32'h00000002, 8'h02, 2, -1, 0, -1, 0);
    run_gap(0, 0, 0);
    chk("drop_b2b_final", drop_cnt, 1);

    // word arriving in the cycle the pending slot is consumed
    send_meas(32'h10203040);
    run_frame(32'h10203040, 8'hA0, 2, 2, 32'hCAFEF00D, -1, 0);
    run_gap(1, 1, 32'hA5A5A5A5);
    chk("drop_simul", drop_cnt, 1);
    run_frame(32'hCAFEF00D, 8'hC5, 1, -1, 0, -1, 0);
    run_gap(1, 0, 0);
    run_frame(32'hA5A5A5A5, 8'h94, 1, -1, 0, -1, 0);
    run_gap(0, 0, 0);
    chk("drop_simul_final", drop_cnt, 1);

    // reset mid-frame
    send_meas(32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("rst_pre_byte", tx_data, eb(32'hDEADBEEF, 8'h38, i));
      @(negedge sys_clk);
      tx_done = 1'b1;
      @(negedge sys_clk);
      tx_done = 1'b0;
    end
    chk("rst_byte3_en", tx_en, 1);
    chk("rst_byte3_data", tx_data, 8'hBE);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    en_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tx_done = (k == 3);
      @(negedge sys_clk);
      if (tx_en) en_seen++;
    end
    tx_done = 1'b0;
    chk("no_tx_en_after_reset", en_seen, 0);
    chk("idle_after_reset", busy, 0);
    send_meas(32'h0F0F0F0F);
    run_frame(32'h0F0F0F0F, 8'h3C, 1, -1, 0, -1, 0);
    run_gap(0, 0, 0);

    // drop counter saturation with a stalled transmitter
    send_meas(32'h11111111);
    chk("sat_header", tx_en, 1);
    en_seen = 0;
    for (int n = 0; n < 301; n++) begin
      meas_data  = n;
      meas_valid = 1'b1;
      @(negedge sys_clk);
      if (tx_en) en_seen++;
      if (n == 255) chk("drop_before_sat", drop_cnt, 255);
    end
    meas_valid = 1'b0;
    @(negedge sys_clk);
    chk("drop_saturated", drop_cnt, 255);
    chk("no_tx_en_while_stalled", en_seen, 0);
    chk("busy_while_stalled", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("drop_cleared_by_reset", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
